// File: rtl/spi_burst_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_burst_bridge                                             |
// | Description : SPI mode-0 slave to register-file bridge. SCLK/CS_N/MOSI are  |
// |               synchronised into clk; frames are a CMD word {WR,INC,ADDR}   |
// |               followed by any number of DATA words, with optional address  |
// |               auto-increment. Single-cycle rd_en/wr_en strobes.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_burst_bridge #(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi_in,
  output logic              miso_out,
  output logic              miso_oe,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              frame_err
);

  localparam int CMD_W  = ADDR_W + 2;
  localparam int SH_W   = (CMD_W > DATA_W) ? CMD_W : DATA_W;
  localparam int CNT_W  = $clog2(SH_W + 1);
  localparam int OCNT_W = $clog2(DATA_W + 1);
  localparam int FILL_W = $clog2(SYNC_STAGES + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  // ---------------------------------------------------------------------------
  // Input synchronisers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_d1_q, cs_d1_q;
  logic [FILL_W-1:0]      fill_q;
  logic                   armed_q;

  logic s_sclk, s_cs, s_mosi;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  assign s_sclk    = sclk_sync_q[SYNC_STAGES-1];
  assign s_cs      = cs_sync_q[SYNC_STAGES-1];
  assign s_mosi    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = s_sclk & ~sclk_d1_q;
  assign sclk_fall = ~s_sclk & sclk_d1_q;
  assign cs_rise   = s_cs & ~cs_d1_q;
  assign cs_fall   = ~s_cs & cs_d1_q;

  // Synchroniser chains; armed_q only sets once the chain holds real samples
  // and CS is seen high, so a reset taken mid-frame cannot fake a CS fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_d1_q   <= 1'b0;
      cs_d1_q     <= 1'b1;
      fill_q      <= '0;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
      sclk_d1_q   <= s_sclk;
      cs_d1_q     <= s_cs;
      if (fill_q != FILL_W'(SYNC_STAGES)) begin
        fill_q <= fill_q + FILL_W'(1);
      end
      if ((fill_q == FILL_W'(SYNC_STAGES)) && s_cs) begin
        armed_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame state
  // ---------------------------------------------------------------------------
  logic [1:0]        state_q,   state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [OCNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [SH_W-1:0]   sh_in_q,   sh_in_d;
  logic [DATA_W-1:0] sh_out_q,  sh_out_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic              wr_mode_q, wr_mode_d;
  logic              inc_q,     inc_d;
  logic              miso_q,    miso_d;
  logic              rd_en_q,   rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_load_q, rd_load_d;
  logic              wr_en_q,   wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              err_q,     err_d;

  logic [SH_W-1:0]   sh_next;
  logic [ADDR_W-1:0] addr_step;

  assign sh_next   = {sh_in_q[SH_W-2:0], s_mosi};
  assign addr_step = inc_q ? (addr_q + ADDR_W'(1)) : addr_q;

  // Next-state logic: CS rise dominates any same-cycle SCLK edge.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    out_cnt_d = out_cnt_q;
    sh_in_d   = sh_in_q;
    sh_out_d  = sh_out_q;
    addr_d    = addr_q;
    wr_mode_d = wr_mode_q;
    inc_d     = inc_q;
    miso_d    = miso_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_load_d = rd_en_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = 1'b0;

    // Read data arrives one clock after the strobe.
    if (rd_load_q) begin
      sh_out_d = rd_data;
    end

    if (cs_rise) begin
      if ((state_q != ST_IDLE) && (bit_cnt_q != '0)) begin
        err_d = 1'b1;
      end
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      out_cnt_d = '0;
      miso_d    = 1'b0;
    end else if (cs_fall && armed_q && (state_q == ST_IDLE)) begin
      state_d   = ST_CMD;
      bit_cnt_d = '0;
      out_cnt_d = '0;
      sh_in_d   = '0;
      miso_d    = 1'b0;
    end else if (state_q != ST_IDLE) begin
      if (sclk_rise) begin
        sh_in_d = sh_next;
        if (state_q == ST_CMD) begin
          if (bit_cnt_q == CNT_W'(CMD_W - 1)) begin
            wr_mode_d = sh_next[CMD_W-1];
            inc_d     = sh_next[CMD_W-2];
            addr_d    = sh_next[ADDR_W-1:0];
            bit_cnt_d = '0;
            out_cnt_d = '0;
            state_d   = ST_DATA;
            if (!sh_next[CMD_W-1]) begin
              rd_en_d   = 1'b1;
              rd_addr_d = sh_next[ADDR_W-1:0];
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else begin
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            bit_cnt_d = '0;
            if (wr_mode_q) begin
              wr_en_d   = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = sh_next[DATA_W-1:0];
              addr_d    = addr_step;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end else if (sclk_fall && (state_q == ST_DATA) && !wr_mode_q) begin
        miso_d   = sh_out_q[DATA_W-1];
        sh_out_d = {sh_out_q[DATA_W-2:0], 1'b0};
        if (out_cnt_q == OCNT_W'(DATA_W - 1)) begin
          // Word fully shifted out: fetch the next one before the next fall.
          out_cnt_d = '0;
          addr_d    = addr_step;
          rd_en_d   = 1'b1;
          rd_addr_d = addr_step;
        end else begin
          out_cnt_d = out_cnt_q + OCNT_W'(1);
        end
      end
    end
  end

  // State registers; reset clears every output and counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      out_cnt_q <= '0;
      sh_in_q   <= '0;
      sh_out_q  <= '0;
      addr_q    <= '0;
      wr_mode_q <= 1'b0;
      inc_q     <= 1'b0;
      miso_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_load_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      out_cnt_q <= out_cnt_d;
      sh_in_q   <= sh_in_d;
      sh_out_q  <= sh_out_d;
      addr_q    <= addr_d;
      wr_mode_q <= wr_mode_d;
      inc_q     <= inc_d;
      miso_q    <= miso_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      rd_load_q <= rd_load_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
    end
  end

  assign miso_out  = miso_q;
  assign miso_oe   = ~s_cs;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = (state_q != ST_IDLE);
  assign frame_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_burst_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_spi_burst_bridge                                          |
// | Description : Scoreboard testbench for spi_burst_bridge. A bit-banged SPI  |
// |               master drives frames; expected strobes and MISO words are    |
// |               queued when stimulus is issued and checked on DUT output.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_spi_burst_bridge;

  localparam int AW = 6;
  localparam int DW = 8;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          sclk, cs_n, mosi_in;
  logic          miso_out, miso_oe, rd_en, wr_en, busy, frame_err;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] rd_data, wr_data;

  int n_cmp = 0;
  int n_bad = 0;
  int half  = 8;
  int err_seen = 0;

  logic [AW+DW-1:0] exp_wr[$];
  logic [AW-1:0]    exp_rd[$];
  logic [DW-1:0]    exp_miso[$];

  spi_burst_bridge #(.ADDR_W(AW), .DATA_W(DW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi_in(mosi_in),
    .miso_out(miso_out), .miso_oe(miso_oe), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Register-file model seen by the bridge.
  function automatic logic [DW-1:0] f_rd(input logic [AW-1:0] a);
    logic [DW-1:0] t;
    t = DW'(a) * 8'd13;
    return t ^ 8'h5A;
  endfunction

  assign rd_data = f_rd(rd_addr);

  function automatic logic [31:0] outs();
    return {6'b0, miso_out, miso_oe, rd_en, wr_en, busy, frame_err, rd_addr, wr_addr, wr_data};
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Strobe monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        if (exp_wr.size() == 0) chk("wr_unexpected", {18'b0, wr_en, wr_addr, wr_data}, 32'h0);
        else                    chk("wr", {18'b0, wr_addr, wr_data}, {18'b0, exp_wr.pop_front()});
      end
      if (rd_en) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", {25'b0, rd_en, rd_addr}, 32'h0);
        else                    chk("rd_addr", {26'b0, rd_addr}, {26'b0, exp_rd.pop_front()});
      end
      if (frame_err) err_seen++;
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Shift n bits MSB-first; miso is sampled just before each rising SCLK.
  task automatic xfer(input logic [31:0] val, input int n, output logic [31:0] rx);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi_in = val[i];
      clks(half);
      rx = {rx[30:0], miso_out};
      sclk = 1'b1;
      clks(half);
      sclk = 1'b0;
    end
  endtask

  task automatic frame_begin();
    cs_n = 1'b0;
    clks(half);
  endtask

  task automatic frame_end();
    clks(half);
    cs_n = 1'b1;
    clks(4 * half);
  endtask

  // Read-data words checked against the queue filled when the command was sent.
  task automatic read_words(input int n);
    logic [31:0] rx;
    for (int w = 0; w < n; w++) begin
      xfer(32'h0, DW, rx);
      if (exp_miso.size() == 0) chk("miso_unexpected", rx, 32'hFFFF_FFFF);
      else                      chk("miso_word", rx, {24'b0, exp_miso.pop_front()});
    end
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] rx;
    rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi_in = 1'b0;
    clks(5);
    chk("reset_outs", outs(), 32'h0);
    rst = 1'b0;
    clks(10);
    chk("idle_busy", {31'b0, busy}, 32'h0);

    // 1: single write
    frame_begin();
    xfer(32'h8A, 8, rx);
    chk("busy_mid", {31'b0, busy}, 32'h1);
    chk("miso_oe_mid", {31'b0, miso_oe}, 32'h1);
    exp_wr.push_back({6'h0A, 8'h5C});
    xfer(32'h5C, 8, rx);
    chk("miso_wr_frame", rx, 32'h0);
    frame_end();
    chk("t1_err", err_seen, 0);

    // 2: read burst with increment and address wrap
    frame_begin();
    exp_rd.push_back(6'h3E); exp_rd.push_back(6'h3F);
    exp_rd.push_back(6'h00); exp_rd.push_back(6'h01);
    exp_miso.push_back(f_rd(6'h3E)); exp_miso.push_back(f_rd(6'h3F));
    exp_miso.push_back(f_rd(6'h00));
    xfer(32'h7E, 8, rx);
    chk("miso_cmd_phase", rx, 32'h0);
    read_words(3);
    frame_end();
    chk("t2_err", err_seen, 0);

    // 3: write burst without increment
    frame_begin();
    xfer(32'h85, 8, rx);
    exp_wr.push_back({6'h05, 8'h11});
    xfer(32'h11, 8, rx);
    exp_wr.push_back({6'h05, 8'h22});
    xfer(32'h22, 8, rx);
    frame_end();

    // 4: abort after a partial data word
    frame_begin();
    xfer(32'h81, 8, rx);
    xfer(32'h15, 5, rx);
    frame_end();
    chk("t4_err_once", err_seen, 1);
    chk("t4_busy", {31'b0, busy}, 32'h0);
    chk("t4_miso_oe", {31'b0, miso_oe}, 32'h0);

    // 5: reset mid-write, CS still low afterwards must not start a frame
    frame_begin();
    xfer(32'h8A, 8, rx);
    xfer(32'h5, 4, rx);
    rst = 1'b1;
    clks(1);
    chk("rst_mid_outs", outs(), 32'h0);
    clks(2);
    rst = 1'b0;
    clks(20);
    chk("no_restart", {31'b0, busy}, 32'h0);
    cs_n = 1'b1;
    clks(10);
    frame_begin();
    xfer(32'h8A, 8, rx);
    exp_wr.push_back({6'h0A, 8'h5C});
    xfer(32'h5C, 8, rx);
    frame_end();

    // 6: minimum SCLK timing, 8-word incrementing read
    half = SS + 3;
    frame_begin();
    for (int a = 0; a < 9; a++) exp_rd.push_back(6'h10 + 6'(a));
    for (int a = 0; a < 8; a++) exp_miso.push_back(f_rd(6'h10 + 6'(a)));
    xfer(32'h50, 8, rx);
    read_words(8);
    frame_end();

    clks(20);
    chk("err_total", err_seen, 1);
    chk("wr_left", exp_wr.size(), 0);
    chk("rd_left", exp_rd.size(), 0);
    chk("miso_left", exp_miso.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
